// File: rtl/button_event_pkg.sv
// Shared types and board defaults for the debounced-switch event decoder.
// Default limits assume the 25 MHz board clock.
package button_event_pkg;

    typedef enum logic [1:0] {
        WAIT_RELEASE,
        IDLE,
        PRESS,
        GAP
    } state_t;

    localparam int DEFAULT_LONG_PRESS_LIMIT = 12_500_000; // 0.5 s
    localparam int DEFAULT_DOUBLE_GAP_LIMIT = 6_250_000;  // 0.25 s

endpackage

// File: rtl/button_event_decoder_press_timer.sv
// press_timer: cycle counter with clear/enable and a terminal-count flag
// compared against a limit that the caller may switch at runtime.
module press_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced switch level into one-cycle short/long/double press events.
// Define DOUBLE_CLICK_EN to enable the release gap window and o_Double_Press.
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int LONG_PRESS_LIMIT = DEFAULT_LONG_PRESS_LIMIT,
    parameter int DOUBLE_GAP_LIMIT = DEFAULT_DOUBLE_GAP_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Short_Press,
    output logic o_Long_Press,
    output logic o_Double_Press,
    output logic o_Busy
);

    localparam int MAX_LIMIT = (LONG_PRESS_LIMIT > DOUBLE_GAP_LIMIT) ?
                               LONG_PRESS_LIMIT : DOUBLE_GAP_LIMIT;
    localparam int CNT_W = $clog2(MAX_LIMIT);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_LIMIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_LIMIT - 1);

    state_t state;
    logic   timing;
    logic   leave;
    logic   at_terminal;

`ifdef DOUBLE_CLICK_EN
    logic double_press;
    assign o_Double_Press = double_press;
`else
    assign o_Double_Press = 1'b0;
`endif

    // The timer runs only in PRESS/GAP and clears on the edge that leaves them.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        timing = 1'b0;
        leave  = 1'b0;
        case (state)
            PRESS: begin
                timing = 1'b1;
                leave  = !i_Switch || at_terminal;
            end
            GAP: begin
                timing = 1'b1;
                leave  = i_Switch || at_terminal;
            end
            default: ;
        endcase
    end

    press_timer #(
        .WIDTH(CNT_W)
    ) u_press_timer (
        .clk        (i_Clk),
        .rst_n      (i_Rst_L),
        .clear      (!timing || leave),
        .enable     (timing),
        .terminal   ((state == GAP) ? GAP_LAST : LONG_LAST),
        .at_terminal(at_terminal)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= WAIT_RELEASE;
            o_Short_Press <= 1'b0;
            o_Long_Press  <= 1'b0;
`ifdef DOUBLE_CLICK_EN
            double_press  <= 1'b0;
`endif
        end else begin
            o_Short_Press <= 1'b0;
            o_Long_Press  <= 1'b0;
`ifdef DOUBLE_CLICK_EN
            double_press  <= 1'b0;
`endif
            case (state)
                WAIT_RELEASE: if (!i_Switch) state <= IDLE;
                IDLE:         if (i_Switch) state <= PRESS;
                PRESS: begin
                    if (!i_Switch) begin
`ifdef DOUBLE_CLICK_EN
                        state <= GAP;
`else
                        o_Short_Press <= 1'b1;
                        state         <= IDLE;
`endif
                    end else if (at_terminal) begin
                        o_Long_Press <= 1'b1;
                        state        <= WAIT_RELEASE;
                    end
                end
                GAP: begin
`ifdef DOUBLE_CLICK_EN
                    // A press on the terminal edge still counts as a double press.
                    if (i_Switch) begin
                        double_press <= 1'b1;
                        state        <= WAIT_RELEASE;
                    end else if (at_terminal) begin
                        o_Short_Press <= 1'b1;
                        state         <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= WAIT_RELEASE;
            endcase
        end
    end

    assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder (LONG=8, GAP=4); follows
// DOUBLE_CLICK_EN the same way the design does.
module tb_button_event_decoder;

    localparam int LONG_L = 8;
    localparam int GAP_L  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic sw    = 1'b1;
    logic short_p, long_p, dbl_p, busy;

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_PRESS_LIMIT(LONG_L),
        .DOUBLE_GAP_LIMIT(GAP_L)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Switch      (sw),
        .o_Short_Press (short_p),
        .o_Long_Press  (long_p),
        .o_Double_Press(dbl_p),
        .o_Busy        (busy)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Timestamp model: a press started at edge press_at becomes long once
    // LONG_L further edges have all seen the switch high; a release at edge
    // rel_at becomes a short after GAP_L low edges, or a double on any high.
    int cyc      = 0;
    int press_at = -1;
    int rel_at   = -1;
    bit ready    = 1'b0;   // a low level has been seen since reset/long/double
    bit e_short  = 1'b0;
    bit e_long   = 1'b0;
    bit e_dbl    = 1'b0;
    bit e_busy   = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_at = -1;
            rel_at   = -1;
            ready    = 1'b0;
            e_short  = 1'b0;
            e_long   = 1'b0;
            e_dbl    = 1'b0;
            e_busy   = 1'b1;
        end else begin
            cyc++;
            e_short = 1'b0;
            e_long  = 1'b0;
            e_dbl   = 1'b0;
            if (press_at >= 0) begin
                if (!sw) begin
`ifdef DOUBLE_CLICK_EN
                    rel_at = cyc;
`else
                    e_short = 1'b1;
`endif
                    press_at = -1;
                end else if (cyc - press_at == LONG_L) begin
                    e_long   = 1'b1;
                    press_at = -1;
                    ready    = 1'b0;
                end
            end else if (rel_at >= 0) begin
                if (sw) begin
                    e_dbl  = 1'b1;
                    rel_at = -1;
                    ready  = 1'b0;
                end else if (cyc - rel_at == GAP_L) begin
                    e_short = 1'b1;
                    rel_at  = -1;
                end
            end else if (!ready) begin
                if (!sw) ready = 1'b1;
            end else if (sw) begin
                press_at = cyc;
            end
            e_busy = (press_at >= 0) || (rel_at >= 0) || !ready;
        end
    end

    // Per-cycle compare plus pulse bookkeeping for the literal checks.
    int n_short = 0, n_long = 0, n_dbl = 0;
    int t_short = 0, t_long = 0, t_dbl = 0;

    always @(negedge clk) begin
        check("short_pulse", int'(short_p), int'(e_short));
        check("long_pulse",  int'(long_p),  int'(e_long));
        check("double_pulse", int'(dbl_p), int'(e_dbl));
        check("busy",        int'(busy),    int'(e_busy));
        if (short_p) begin n_short++; t_short = cyc; end
        if (long_p)  begin n_long++;  t_long  = cyc; end
        if (dbl_p)   begin n_dbl++;   t_dbl   = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int c0, s0, l0, d0;

    task automatic snap();
        s0 = n_short;
        l0 = n_long;
        d0 = n_dbl;
    endtask

    initial begin
        // Reset with the switch held, release while still held, then let go.
        #1 rst_n = 1'b0;
        tick(3);
        check("rst_short", int'(short_p), 0);
        check("rst_busy",  int'(busy),    1);
        rst_n = 1'b1;
        tick(20);
        check("held_busy", int'(busy), 1);
        c0 = cyc;
        sw = 1'b0;
        tick(1);
        check("busy_drop_cycle", cyc - c0, 1);
        check("busy_drop", int'(busy), 0);
        check("held_no_events", n_short + n_long + n_dbl, 0);
        tick(3);

        // Short press: 3 cycles high, then low.
        snap();
        sw = 1'b1;
        tick(3);
        c0 = cyc;
        sw = 1'b0;
        tick(8);
        check("short_count", n_short - s0, 1);
`ifdef DOUBLE_CLICK_EN
        check("short_latency", t_short - c0, 5);
`else
        check("short_latency", t_short - c0, 1);
`endif

        // Long press: 15 cycles high, no short on release.
        snap();
        c0 = cyc;
        sw = 1'b1;
        tick(15);
        sw = 1'b0;
        tick(8);
        check("long_count", n_long - l0, 1);
        check("long_latency", t_long - c0, 9);
        check("long_no_short", n_short - s0, 0);

        // Double press: 2 high, 2 low, high again.
        snap();
        sw = 1'b1;
        tick(2);
        sw = 1'b0;
        tick(2);
        c0 = cyc;
        sw = 1'b1;
        tick(2);
        sw = 1'b0;
        tick(8);
`ifdef DOUBLE_CLICK_EN
        check("dbl_count", n_dbl - d0, 1);
        check("dbl_latency", t_dbl - c0, 1);
        check("dbl_no_short", n_short - s0, 0);
`else
        check("dbl_count", n_dbl - d0, 0);
        check("dbl_as_shorts", n_short - s0, 2);
`endif

        // Press arriving on the gap terminal-count edge wins.
        snap();
        sw = 1'b1;
        tick(2);
        c0 = cyc;
        sw = 1'b0;
        tick(4);
        sw = 1'b1;
        tick(2);
        sw = 1'b0;
        tick(8);
`ifdef DOUBLE_CLICK_EN
        check("tie_dbl_count", n_dbl - d0, 1);
        check("tie_dbl_latency", t_dbl - c0, 5);
        check("tie_no_short", n_short - s0, 0);
`else
        check("tie_dbl_count", n_dbl - d0, 0);
        check("tie_as_shorts", n_short - s0, 2);
`endif

        // Reset while in the release gap drops the pending event.
        snap();
        sw = 1'b1;
        tick(2);
        sw = 1'b0;
        tick(2);
        rst_n = 1'b0;
        #1;
        check("gap_rst_short", int'(short_p), 0);
        check("gap_rst_long",  int'(long_p),  0);
        check("gap_rst_dbl",   int'(dbl_p),   0);
        check("gap_rst_busy",  int'(busy),    1);
        tick(3);
        rst_n = 1'b1;
        tick(10);
`ifdef DOUBLE_CLICK_EN
        check("gap_rst_no_short", n_short - s0, 0);
`else
        check("gap_rst_no_short", n_short - s0, 1);
`endif
        check("gap_rst_no_other", (n_long - l0) + (n_dbl - d0), 0);
        check("final_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
